rr_scan_arbiter: RTL and testbench
==================================

RR_SCAN_ARBITER -- requirements
Module: rr_scan_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  request from requesters 3..0; level-sensitive, held high while the lane is wanted.
REQ-005 Port: grant  output  4  one-hot grant; all-zero when no owner.
REQ-006 Port: sel  output  2  binary index of current owner, driving the shared 4:1 mux select; holds last owner when grant is zero.
REQ-007 Port: busy  output  1  high whenever grant is non-zero.
REQ-008 Port: preempt  output  1  one-cycle pulse in the cycle after a grant is forcibly withdrawn by MAX_HOLD.

Function
REQ-009 The block SHALL implement a three-state FSM: IDLE, GRANT, GAP; all outputs SHALL be registered.
REQ-010 IDLE: if any req bit is high, the block SHALL select a winner and enter GRANT, with grant asserted on the next rising edge (1-cycle latency); otherwise it SHALL remain in IDLE.
REQ-011 Winner selection SHALL be round-robin: search order last+1, last+2, last+3, last (mod 4), where last is the most recent owner index.
REQ-012 On entering GRANT, last SHALL update to the winner, sel SHALL equal the winner index and hold_cnt SHALL load 1.
REQ-013 GRANT: each cycle with req[owner] high and hold_cnt < MAX_HOLD, the grant SHALL stay unchanged and hold_cnt SHALL increment by 1.
REQ-014 GRANT: if req[owner] is low, the block SHALL enter GAP on the next edge with no preempt pulse.
REQ-015 GRANT: if req[owner] is high and hold_cnt == MAX_HOLD, the block SHALL enter GAP and assert preempt for exactly one cycle.
REQ-016 When req[owner] falls in the same cycle that hold_cnt reaches MAX_HOLD, the release SHALL be treated as voluntary (no preempt).
REQ-017 GAP: grant SHALL be all-zero for exactly one cycle; if any req is high, a new winner per REQ-011 SHALL be granted on the next edge, otherwise the FSM SHALL go to IDLE.
REQ-018 A preempted requester that keeps req high SHALL be granted again only after every other active requester has been served once.
REQ-019 With MAX_HOLD == 1, each grant SHALL last exactly one cycle followed by one GAP cycle.
REQ-020 Changes to non-owner req bits during GRANT SHALL NOT affect the current grant.
REQ-021 hold_cnt SHALL be 4 bits wide and SHALL never exceed MAX_HOLD.

Reset
REQ-022 While reset is high: state = IDLE, grant = 4'b0000, sel = 2'b00, busy = 0, preempt = 0, hold_cnt = 0, last = 3 (so requester 0 has first priority).
REQ-023 Reset asserted mid-grant SHALL clear grant immediately (asynchronously), without a preempt pulse.
REQ-024 After reset deassertion, the first arbitration SHALL occur on the first rising edge with reset low.

Structure
REQ-025 A shared package SHALL hold the FSM state enumeration (IDLE, GRANT, GAP), NUM_REQ = 4 and the hold_cnt width constant.
REQ-026 Round-robin winner computation SHALL be a combinational sub-module rr_pick (inputs: req, last; outputs: any, winner index).
REQ-027 The FSM, hold counter and output registers SHALL reside in rr_scan_arbiter.

Verification
REQ-028 After reset, req=4'b0101 held -> grant=0001, sel=0 one cycle after first edge; after release of req0, GAP then grant=0100, sel=2.
REQ-029 MAX_HOLD=8, req=4'b0010 held continuously -> grant=0010 for 8 cycles, preempt pulses once, 1 GAP cycle, then grant=0010 again.
REQ-030 req=4'b1111 held, MAX_HOLD=2 -> grant order 0001,0010,0100,1000,0001, each 2 cycles with a 1-cycle zero gap between.
REQ-031 Owner 1 drops req at hold_cnt=MAX_HOLD -> next-cycle GAP with preempt=0.
REQ-032 Reset asserted during grant=0100 -> grant=0000, sel=0, busy=0 before the next clock edge; first post-reset grant goes to lowest active index.
REQ-033 req=4'b0000 for 10 cycles after reset -> state stays IDLE, busy=0, grant=0000 throughout.

Source files
------------

// File: rtl/rr_scan_arbiter_pkg.sv
// Shared definitions for the round-robin scan arbiter.
// It holds the FSM state encoding, the requester count, the index and hold-counter
// widths, and a one-hot decode helper.
package rr_scan_arbiter_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned HOLD_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Decode a requester index into a one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_scan_arbiter_rr_pick.sv
// Combinational round-robin winner search.
// The search starts one past the previous owner and wraps, so the previous owner
// is checked last.
// Ports:
//   req    - request vector
//   last   - index of the most recent owner
//   any    - high when at least one request is active
//   winner - index of the selected requester; equals last when any is low
module rr_pick
   import rr_scan_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               any,
   output logic [IDX_W-1:0]   winner
);

   logic [IDX_W-1:0] idx;

   // First active request in the order last+1, last+2, last+3, last (mod 4).
   always_comb begin
      any    = 1'b0;
      winner = last;
      idx    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = last + IDX_W'(k);
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/rr_scan_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time.
// An owner keeps the grant while its request stays high, for at most MAX_HOLD
// cycles. A grant that ends is always followed by one cycle with no grant.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous, active-high reset
//   req     - level requests from requesters 3..0
//   grant   - one-hot grant, zero when there is no owner
//   sel     - index of the current owner, held after the grant ends
//   busy    - high whenever grant is non-zero
//   preempt - one-cycle pulse after a grant is withdrawn because MAX_HOLD expired
module rr_scan_arbiter
   import rr_scan_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   sel,
   output logic               busy,
   output logic               preempt
);

   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

   state_t             state, state_nxt;
   logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
   logic [IDX_W-1:0]   last, last_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [IDX_W-1:0]   sel_nxt;
   logic               busy_nxt;
   logic               preempt_nxt;

   logic               pick_any;
   logic [IDX_W-1:0]   pick_winner;

   rr_pick u_rr_pick (
      .req    (req),
      .last   (last),
      .any    (pick_any),
      .winner (pick_winner)
   );

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
         last     <= IDX_W'(NUM_REQ - 1);
         grant    <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         preempt  <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         last     <= last_nxt;
         grant    <= grant_nxt;
         sel      <= sel_nxt;
         busy     <= busy_nxt;
         preempt  <= preempt_nxt;
      end
   end

   // Next-state and next-output logic. In GRANT, last is the current owner.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      last_nxt     = last;
      grant_nxt    = '0;
      sel_nxt      = sel;
      busy_nxt     = 1'b0;
      preempt_nxt  = 1'b0;

      unique case (state)
         IDLE, GAP: begin
            if (pick_any) begin
               state_nxt    = GRANT;
               last_nxt     = pick_winner;
               sel_nxt      = pick_winner;
               grant_nxt    = onehot(pick_winner);
               busy_nxt     = 1'b1;
               hold_cnt_nxt = HOLD_W'(1);
            end else begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (req[last] && (hold_cnt < HOLD_LIMIT)) begin
               grant_nxt    = grant;
               busy_nxt     = 1'b1;
               hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end else begin
               // A release at the hold limit counts as voluntary; only a
               // still-asserted request is a forced withdrawal.
               state_nxt    = GAP;
               hold_cnt_nxt = '0;
               preempt_nxt  = req[last];
            end
         end
         default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_rr_scan_arbiter.sv
// Self-checking bench for rr_scan_arbiter.
// Three instances (MAX_HOLD = 8, 2, 1) share one stimulus stream, and each is
// compared every cycle against a request/owner-level reference model.
module tb_rr_scan_arbiter;

   localparam int NDUT = 3;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant_v   [NDUT];
   logic [1:0] sel_v     [NDUT];
   logic       busy_v    [NDUT];
   logic       preempt_v [NDUT];

   int checks;
   int errors;

   // Reference model: owner index (-1 = nobody), cycles held, previous owner.
   int m_owner [NDUT];
   int m_held  [NDUT];
   int m_last  [NDUT];
   int m_sel   [NDUT];
   bit m_pre   [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      rr_scan_arbiter #(.MAX_HOLD((g == 0) ? 8 : ((g == 1) ? 2 : 1))) u_dut (
         .clk     (clk),
         .reset   (reset),
         .req     (req),
         .grant   (grant_v[g]),
         .sel     (sel_v[g]),
         .busy    (busy_v[g]),
         .preempt (preempt_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int mh(input int g);
      return (g == 0) ? 8 : ((g == 1) ? 2 : 1);
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int g = 0; g < NDUT; g++) begin
         m_owner[g] = -1;
         m_held[g]  = 0;
         m_last[g]  = 3;
         m_sel[g]   = 0;
         m_pre[g]   = 1'b0;
      end
   endtask

   // One rising edge's worth of arbitration behaviour.
   task automatic model_edge(input logic [3:0] r);
      for (int g = 0; g < NDUT; g++) begin
         m_pre[g] = 1'b0;
         if (m_owner[g] >= 0) begin
            if (r[m_owner[g]] && m_held[g] < mh(g)) begin
               m_held[g]++;
            end else begin
               m_pre[g]   = r[m_owner[g]];
               m_owner[g] = -1;
               m_held[g]  = 0;
            end
         end else begin
            for (int k = 1; k <= 4; k++) begin
               int w;
               w = (m_last[g] + k) % 4;
               if (m_owner[g] < 0 && r[w]) begin
                  m_owner[g] = w;
                  m_last[g]  = w;
                  m_sel[g]   = w;
                  m_held[g]  = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all(input string phase);
      logic [3:0] eg;
      for (int g = 0; g < NDUT; g++) begin
         eg = 4'b0000;
         if (m_owner[g] >= 0) eg[m_owner[g]] = 1'b1;
         check($sformatf("%s grant[d%0d]", phase, g), grant_v[g], eg);
         check($sformatf("%s sel[d%0d]", phase, g), {2'b00, sel_v[g]}, 4'(m_sel[g]));
         check($sformatf("%s busy[d%0d]", phase, g), {3'b000, busy_v[g]}, {3'b000, (m_owner[g] >= 0)});
         check($sformatf("%s preempt[d%0d]", phase, g), {3'b000, preempt_v[g]}, {3'b000, m_pre[g]});
      end
   endtask

   // Drive req, take one rising edge, then sample 1 time unit later.
   task automatic step(input string phase, input logic [3:0] r);
      req = r;
      @(posedge clk);
      if (reset) model_reset();
      else       model_edge(r);
      #1;
      check_all(phase);
   endtask

   initial begin
      logic [3:0] r;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      req    = 4'b0000;
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b0;

      // No requests: stay idle.
      repeat (10) step("idle", 4'b0000);

      // Two requesters: 0 wins first, then 2 after req0 is released.
      step("r0101", 4'b0101);
      check("first_grant", grant_v[0], 4'b0001);
      check("first_sel", {2'b00, sel_v[0]}, 4'd0);
      repeat (3) step("r0101", 4'b0101);
      step("rel0", 4'b0100);
      check("gap_grant", grant_v[0], 4'b0000);
      step("r0100", 4'b0100);
      check("second_grant", grant_v[0], 4'b0100);
      check("second_sel", {2'b00, sel_v[0]}, 4'd2);
      repeat (2) step("drain", 4'b0000);

      // Single requester held: preempt at the hold limit, then granted again.
      repeat (22) step("hold1", 4'b0010);
      repeat (2) step("drain", 4'b0000);

      // All requesters: round-robin rotation.
      repeat (24) step("all", 4'b1111);
      repeat (2) step("drain", 4'b0000);

      // Release exactly at the hold limit is voluntary (MAX_HOLD=2 instance).
      step("lim", 4'b0010);
      step("lim", 4'b0010);
      step("lim_rel", 4'b0000);
      check("vol_grant", grant_v[1], 4'b0000);
      check("vol_preempt", {3'b000, preempt_v[1]}, 4'b0000);
      step("drain", 4'b0000);

      // Asynchronous reset in the middle of a grant.
      step("pre_rst", 4'b0100);
      check("pre_rst_grant", grant_v[0], 4'b0100);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      step("in_rst", 4'b0110);
      #2;
      reset = 1'b0;
      step("post_rst", 4'b0110);
      check("post_rst_grant", grant_v[0], 4'b0010);

      // Random request traffic, mostly stable so holds can run to the limit.
      r = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) r[$urandom_range(3)] = ~r[$urandom_range(3)];
         if ($urandom_range(15) == 0) r = 4'($urandom_range(15));
         step("rand", r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
